// File: rtl/y_multicycle_ctrl.sv
// Multicycle control FSM for the yIF/yID/yEX datapath: latches the fetched instruction and sequences it.
// Retires in 3-5 clocks depending on opcode; there is no backpressure and unknown opcodes park in TRAP until reset.
module y_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic [31:0] PCp4,
    input  logic [31:0] branch,
    input  logic [31:0] jTarget,
    output logic [31:0] PCin,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [2:0]  op,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic        Link,
    output logic        illegal,
    output logic        done,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LW  = 7'h03;
    localparam logic [6:0] OPC_SW  = 7'h23;
    localparam logic [6:0] OPC_BEQ = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        r_illegal;

    logic [6:0]  w_opc;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_is_jal, w_legal;
    logic        w_last;
    logic [2:0]  w_dec_op;
    logic        w_dec_src;
    logic        w_unused_ir;

    assign w_opc    = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];
    assign w_unused_ir = &{1'b0, r_ir[24:15], r_ir[11:7]};

    assign w_is_r   = (w_opc == OPC_R);
    assign w_is_i   = (w_opc == OPC_I);
    assign w_is_lw  = (w_opc == OPC_LW);
    assign w_is_sw  = (w_opc == OPC_SW);
    assign w_is_beq = (w_opc == OPC_BEQ);
    assign w_is_jal = (w_opc == OPC_JAL);
    assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_beq | w_is_jal;

    // Final state of each instruction: this edge retires it and moves the PC.
    assign w_last = (r_state == S_WB)
                  | ((r_state == S_MEM)  & w_is_sw)
                  | ((r_state == S_EXEC) & w_is_beq);

    always_comb begin
        w_dec_op  = 3'b000;
        w_dec_src = 1'b0;
        if (w_is_r || w_is_i) begin
            w_dec_src = w_is_i;
            case (w_funct3)
                3'b000:  w_dec_op = (w_is_r && w_funct7 == 7'b0100000) ? 3'b110 : 3'b010;
                3'b111:  w_dec_op = 3'b000;
                3'b110:  w_dec_op = 3'b001;
                3'b010:  w_dec_op = 3'b111;
                default: w_dec_op = 3'b010;
            endcase
        end else if (w_is_lw || w_is_sw) begin
            w_dec_op  = 3'b010;
            w_dec_src = 1'b1;
        end else if (w_is_jal) begin
            w_dec_op  = 3'b010;
        end else if (w_is_beq) begin
            w_dec_op  = 3'b110;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (!w_legal)      w_next = S_TRAP;
                else if (w_is_jal) w_next = S_WB;
                else               w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_beq)                w_next = S_FETCH;
                else if (w_is_lw || w_is_sw) w_next = S_MEM;
                else                         w_next = S_WB;
            end
            S_MEM:    w_next = w_is_lw ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Mem2Reg  = 1'b0;
        Link     = 1'b0;
        op       = 3'b000;
        ALUSrc   = 1'b0;
        done     = 1'b0;
        if (r_state != S_FETCH && r_state != S_TRAP) begin
            op     = w_dec_op;
            ALUSrc = w_dec_src;
            done   = w_last;
        end
        if (r_state == S_WB) begin
            RegWrite = 1'b1;
            Mem2Reg  = w_is_lw;
            Link     = w_is_jal;
        end
        if (r_state == S_MEM) begin
            MemRead  = w_is_lw;
            MemWrite = w_is_sw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= 32'h0;
            r_pc      <= RESET_PC;
            r_instret <= 32'h0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH)
                r_ir <= ins;
            if (w_last) begin
                if (w_is_beq && zero) r_pc <= branch;
                else if (w_is_jal)    r_pc <= jTarget;
                else                  r_pc <= PCp4;
                r_instret <= r_instret + 32'd1;
            end
            if (r_state == S_DECODE && !w_legal)
                r_illegal <= 1'b1;
        end
    end

    assign PCin    = r_pc;
    assign instret = r_instret;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_y_multicycle_ctrl.sv
// Bench for y_multicycle_ctrl: directed instruction sequences with literal expectations, then random
// instruction streams, all cross-checked every cycle against an instruction-position model.
module tb_y_multicycle_ctrl;

    localparam logic [31:0] RST_PC = 32'h28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ins = 32'h0;
    logic        zero = 1'b0;
    logic [31:0] PCp4 = 32'h0;
    logic [31:0] branch = 32'h0;
    logic [31:0] jTarget = 32'h0;
    logic [31:0] PCin;
    logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, Link, illegal, done;
    logic [2:0]  op;
    logic [31:0] instret;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    y_multicycle_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .PCp4(PCp4),
        .branch(branch), .jTarget(jTarget), .PCin(PCin), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
        .Mem2Reg(Mem2Reg), .Link(Link), .illegal(illegal), .done(done),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position k (1-based) inside the current instruction, plus its length.
    int          m_k = 1;
    logic [31:0] m_ir = 32'h0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instret = 32'h0;
    bit          m_ill = 1'b0;
    bit          m_trap = 1'b0;

    function automatic int seq_len(input logic [31:0] ir);
        case (ir[6:0])
            7'h33, 7'h13: return 4;
            7'h03:        return 5;
            7'h23:        return 4;
            7'h63, 7'h6F: return 3;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [2:0] alu_op(input logic [31:0] ir);
        logic sub;
        sub = (ir[6:0] == 7'h33) && (ir[31:25] == 7'h20);
        case (ir[6:0])
            7'h33, 7'h13: begin
                case (ir[14:12])
                    3'd0:    return sub ? 3'b110 : 3'b010;
                    3'd7:    return 3'b000;
                    3'd6:    return 3'b001;
                    3'd2:    return 3'b111;
                    default: return 3'b010;
                endcase
            end
            7'h03, 7'h23, 7'h6F: return 3'b010;
            7'h63:               return 3'b110;
            default:             return 3'b000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 1; m_ir = 32'h0; m_pc = RST_PC; m_instret = 32'h0; m_ill = 1'b0; m_trap = 1'b0;
        end else if (!m_trap) begin
            if (m_k == 1) begin
                m_ir = ins;
                m_k = 2;
            end else if (seq_len(m_ir) == 0) begin
                m_trap = 1'b1;
                m_ill = 1'b1;
            end else if (m_k == seq_len(m_ir)) begin
                if (m_ir[6:0] == 7'h63 && zero) m_pc = branch;
                else if (m_ir[6:0] == 7'h6F)    m_pc = jTarget;
                else                             m_pc = PCp4;
                m_instret = m_instret + 32'd1;
                m_k = 1;
            end else begin
                m_k = m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic active, last, is_lw, is_sw, wb_type;
            logic [6:0] opc;
            opc     = m_ir[6:0];
            active  = !m_trap && m_k >= 2;
            last    = active && seq_len(m_ir) != 0 && m_k == seq_len(m_ir);
            is_lw   = (opc == 7'h03);
            is_sw   = (opc == 7'h23);
            wb_type = (opc == 7'h33) || (opc == 7'h13) || is_lw || (opc == 7'h6F);
            chk("m_PCin", PCin, m_pc);
            chk("m_instret", instret, m_instret);
            chk("m_illegal", {31'd0, illegal}, {31'd0, m_ill});
            chk("m_op", {29'd0, op}, active ? {29'd0, alu_op(m_ir)} : 32'd0);
            chk("m_ALUSrc", {31'd0, ALUSrc},
                {31'd0, active && (opc == 7'h13 || is_lw || is_sw)});
            chk("m_done", {31'd0, done}, {31'd0, last});
            chk("m_RegWrite", {31'd0, RegWrite}, {31'd0, last && wb_type});
            chk("m_Mem2Reg", {31'd0, Mem2Reg}, {31'd0, last && is_lw});
            chk("m_Link", {31'd0, Link}, {31'd0, last && opc == 7'h6F});
            chk("m_MemRead", {31'd0, MemRead}, {31'd0, active && is_lw && m_k == 4});
            chk("m_MemWrite", {31'd0, MemWrite}, {31'd0, active && is_sw && m_k == 4});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 40);
        if (r == 0) begin
            case ($urandom_range(0, 3))
                0:       w[6:0] = 7'h7F;
                1:       w[6:0] = 7'h37;
                2:       w[6:0] = 7'h17;
                default: w[6:0] = 7'h0F;
            endcase
        end else begin
            case (r % 6)
                0:       w[6:0] = 7'h33;
                1:       w[6:0] = 7'h13;
                2:       w[6:0] = 7'h03;
                3:       w[6:0] = 7'h23;
                4:       w[6:0] = 7'h63;
                default: w[6:0] = 7'h6F;
            endcase
            if ($urandom_range(0, 1) == 1) w[31:25] = 7'h20;
            else if ($urandom_range(0, 1) == 1) w[31:25] = 7'h00;
        end
        return w;
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        started = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        // cycle 1: FETCH of add x3,x1,x2
        chk("rst_PCin", PCin, 32'h28);
        chk("rst_instret", instret, 32'h0);
        chk("rst_op", {29'd0, op}, 32'd0);
        ins = 32'h002081B3; PCp4 = 32'h2C;
        tick();
        chk("add_op_dec", {29'd0, op}, 32'd2);
        chk("add_src_dec", {31'd0, ALUSrc}, 32'd0);
        chk("add_rw_c2", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("add_rw_c3", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("add_rw_c4", {31'd0, RegWrite}, 32'd1);
        chk("add_done_c4", {31'd0, done}, 32'd1);
        tick();
        chk("add_PCin", PCin, 32'h2C);
        chk("add_instret", instret, 32'd1);

        ins = 32'h00002283; PCp4 = 32'h30;
        tick();
        chk("lw_src", {31'd0, ALUSrc}, 32'd1);
        tick();
        tick();
        chk("lw_memread_c4", {31'd0, MemRead}, 32'd1);
        chk("lw_rw_c4", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("lw_rw_c5", {31'd0, RegWrite}, 32'd1);
        chk("lw_m2r_c5", {31'd0, Mem2Reg}, 32'd1);
        chk("lw_memread_c5", {31'd0, MemRead}, 32'd0);
        tick();
        chk("lw_PCin", PCin, 32'h30);

        ins = 32'h00502223; PCp4 = 32'h34;
        tick();
        chk("sw_src", {31'd0, ALUSrc}, 32'd1);
        tick();
        tick();
        chk("sw_memwrite_c4", {31'd0, MemWrite}, 32'd1);
        chk("sw_rw_c4", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("sw_PCin", PCin, 32'h34);
        chk("sw_instret", instret, 32'd3);

        ins = 32'h00000463; zero = 1'b1; branch = 32'h30; PCp4 = 32'h38;
        tick();
        chk("beq_op", {29'd0, op}, 32'd6);
        tick();
        chk("beq_done", {31'd0, done}, 32'd1);
        chk("beq_rw", {31'd0, RegWrite | MemRead | MemWrite}, 32'd0);
        tick();
        chk("beq_taken_PCin", PCin, 32'h30);
        zero = 1'b0; PCp4 = 32'h44;
        tick();
        tick();
        tick();
        chk("beq_nt_PCin", PCin, 32'h44);

        ins = 32'h010000EF; jTarget = 32'h38; PCp4 = 32'h48;
        tick();
        tick();
        chk("jal_link_c3", {31'd0, Link}, 32'd1);
        chk("jal_rw_c3", {31'd0, RegWrite}, 32'd1);
        tick();
        chk("jal_PCin", PCin, 32'h38);
        chk("jal_instret", instret, 32'd6);

        ins = 32'h0000007F;
        tick();
        tick();
        chk("trap_illegal", {31'd0, illegal}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            PCp4 = $urandom; zero = 1'b1;
            tick();
        end
        chk("trap_PCin_frozen", PCin, 32'h38);
        chk("trap_instret_frozen", instret, 32'd6);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        chk("trap_rst_PCin", PCin, 32'h28);
        tick();
        rst_n = 1'b1;

        ins = 32'h00002283; PCp4 = 32'h2C;
        tick();
        tick();
        tick();
        chk("midlw_memread", {31'd0, MemRead}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midlw_rst_memread", {31'd0, MemRead}, 32'd0);
        chk("midlw_rst_instret", instret, 32'd0);
        chk("midlw_rst_op", {29'd0, op}, 32'd0);
        tick();
        rst_n = 1'b1;
        ins = 32'h002081B3; PCp4 = 32'h2C;
        for (int i = 0; i < 4; i++) tick();
        chk("midlw_resume_PCin", PCin, 32'h2C);
        chk("midlw_resume_instret", instret, 32'd1);

        begin
            int trap_cycles;
            trap_cycles = 0;
            for (int c = 0; c < 4000; c++) begin
                ins = rand_ins();
                zero = 1'($urandom_range(0, 1));
                PCp4 = $urandom; branch = $urandom; jTarget = $urandom;
                tick();
                trap_cycles = m_trap ? trap_cycles + 1 : 0;
                if (trap_cycles > 20 || $urandom_range(0, 299) == 0) begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    trap_cycles = 0;
                end
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
